pipelined_control_unit: RTL

- Parametrised, registered successor to the combinational decode control unit.
- Decodes the opcode into EX/MEM/WB control bundles and registers them into the ID/EX stage together with the destination register.
- Detects load-use hazards against the instruction in ID/EX and inserts a single bubble.
- Honours downstream hold and flush, flags illegal opcodes, and counts inserted bubbles.

---
 rtl/pipelined_control_unit_if.sv | 37 +++
 rtl/pipelined_control_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit_if.sv
// Handshake and control-bundle bundle between the decode stage and the
// ID/EX register. The decode-side source drives through master; the
// control unit sits on slave.
interface pipelined_control_unit_if #(
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 3,
  parameter int ALUOP_W    = 4,
  parameter int CNT_W      = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OPCODE_W-1:0]   opcode;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic [REG_ADDR_W-1:0] dst;
  logic                  hold;
  logic                  flush;
  logic [ALUOP_W+1:0]    ex_signals;
  logic [3:0]            mem_signals;
  logic [2:0]            wb_signals;
  logic                  out_valid;
  logic [REG_ADDR_W-1:0] out_dst;
  logic                  illegal;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output in_valid, opcode, src1, src2, dst, hold, flush,
    input  in_ready, ex_signals, mem_signals, wb_signals,
    input  out_valid, out_dst, illegal, bubble_cnt
  );

  modport slave (
    input  in_valid, opcode, src1, src2, dst, hold, flush,
    output in_ready, ex_signals, mem_signals, wb_signals,
    output out_valid, out_dst, illegal, bubble_cnt
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Registered decode control unit: decodes the opcode into EX/MEM/WB control
// bundles held in the ID/EX register, inserts a single bubble on a load-use
// hazard, honours downstream hold/flush, flags illegal opcodes and keeps a
// saturating count of hazard bubbles.
module pipelined_control_unit #(
  parameter int OPCODE_W       = 6,
  parameter int REG_ADDR_W     = 3,
  parameter int ALUOP_W        = 4,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  pipelined_control_unit_if.slave bus
);

  localparam int EX_W = ALUOP_W + 2;

  localparam logic [OPCODE_W-1:0] OPC_LDD = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OPC_STD = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OPC_ADD = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OPC_NOT = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OPC_NOP = OPCODE_W'(6'b000101);

  localparam logic [ALUOP_W-1:0] ALU_NOT = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'b0010);

  // NOP bundle doubles as the bubble value
  localparam logic [EX_W-1:0] EX_NOP  = '0;
  localparam logic [3:0]      MEM_NOP = 4'b0000;
  localparam logic [2:0]      WB_NOP  = 3'b011;

  localparam logic STALL_EN = (LOAD_USE_STALL != 0);

  typedef enum logic [2:0] {
    K_NOP,
    K_NOT,
    K_ADD,
    K_LDD,
    K_STD,
    K_ILL
  } op_kind_e;

  op_kind_e              kind;
  logic [EX_W-1:0]       dec_ex;
  logic [3:0]            dec_mem;
  logic [2:0]            dec_wb;
  logic                  dec_illegal;
  logic                  rd_src1;
  logic                  rd_src2;
  logic                  src_match;
  logic                  hz;

  logic [EX_W-1:0]       ex_q, ex_d;
  logic [3:0]            mem_q, mem_d;
  logic [2:0]            wb_q, wb_d;
  logic                  out_valid_q, out_valid_d;
  logic [REG_ADDR_W-1:0] out_dst_q, out_dst_d;
  logic                  illegal_q, illegal_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // classify the incoming opcode; anything outside the table is illegal
  always_comb begin
    case (bus.opcode)
      OPC_NOP: kind = K_NOP;
      OPC_NOT: kind = K_NOT;
      OPC_ADD: kind = K_ADD;
      OPC_LDD: kind = K_LDD;
      OPC_STD: kind = K_STD;
      default: kind = K_ILL;
    endcase
  end

  // control bundles and source-register usage per instruction kind
  always_comb begin
    dec_ex      = EX_NOP;
    dec_mem     = MEM_NOP;
    dec_wb      = WB_NOP;
    dec_illegal = 1'b0;
    rd_src1     = 1'b0;
    rd_src2     = 1'b0;
    case (kind)
      K_NOT: begin
        dec_ex  = {ALU_NOT, 1'b1, 1'b0};
        dec_wb  = 3'b101;
        rd_src1 = 1'b1;
      end
      K_ADD: begin
        dec_ex  = {ALU_ADD, 1'b1, 1'b0};
        dec_wb  = 3'b101;
        rd_src1 = 1'b1;
        rd_src2 = 1'b1;
      end
      K_LDD: begin
        dec_mem = 4'b1000;
        dec_wb  = 3'b100;
        rd_src1 = 1'b1;
      end
      K_STD: begin
        dec_mem = 4'b0110;
        dec_wb  = 3'b011;
        rd_src1 = 1'b1;
        rd_src2 = 1'b1;
      end
      K_ILL: dec_illegal = 1'b1;
      default: ;
    endcase
  end

  // load-use hazard: ID/EX holds a valid load whose destination is read now
  always_comb begin
    src_match = (rd_src1 && (bus.src1 == out_dst_q)) ||
                (rd_src2 && (bus.src2 == out_dst_q));
    hz        = STALL_EN && bus.in_valid && out_valid_q && mem_q[3] && src_match;
  end

  // flush does not back-pressure: the squashed input is simply consumed
  assign bus.in_ready = !bus.hold && !hz;

  // ID/EX next state: flush > hold > hazard bubble > accept > idle bubble
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    out_valid_d = out_valid_q;
    out_dst_d   = out_dst_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    if (bus.flush) begin
      ex_d        = EX_NOP;
      mem_d       = MEM_NOP;
      wb_d        = WB_NOP;
      out_valid_d = 1'b0;
      out_dst_d   = '0;
      illegal_d   = 1'b0;
    end else if (bus.hold) begin
      // everything frozen, including the counter
    end else if (hz) begin
      ex_d        = EX_NOP;
      mem_d       = MEM_NOP;
      wb_d        = WB_NOP;
      out_valid_d = 1'b0;
      out_dst_d   = '0;
      illegal_d   = 1'b0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.in_valid) begin
      ex_d        = dec_ex;
      mem_d       = dec_mem;
      wb_d        = dec_wb;
      out_valid_d = 1'b1;
      out_dst_d   = bus.dst;
      illegal_d   = dec_illegal;
    end else begin
      ex_d        = EX_NOP;
      mem_d       = MEM_NOP;
      wb_d        = WB_NOP;
      out_valid_d = 1'b0;
      out_dst_d   = '0;
      illegal_d   = 1'b0;
    end
  end

  // ID/EX register and bubble counter; reset loads the bubble value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= EX_NOP;
      mem_q       <= MEM_NOP;
      wb_q        <= WB_NOP;
      out_valid_q <= 1'b0;
      out_dst_q   <= '0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      out_valid_q <= out_valid_d;
      out_dst_q   <= out_dst_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.ex_signals  = ex_q;
  assign bus.mem_signals = mem_q;
  assign bus.wb_signals  = wb_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_dst     = out_dst_q;
  assign bus.illegal     = illegal_q;
  assign bus.bubble_cnt  = cnt_q;

endmodule
